// File: rtl/u_dly_cal_ctrl.sv
// Fine delay-line calibration controller: walks a thermometer code one cell at a time
// and stops at the first phase-detector reversal (lock) or at a code boundary (error).
//
// state  | meaning
// IDLE   | waiting for a calibration request
// SETTLE | delay line settling after a code change
// SAMPLE | one-cycle phase-detector evaluation and code step
// LOCK   | reversal seen, code held
// ERR    | code boundary reached without a reversal, code held
module u_dly_cal_ctrl #(
    parameter int N_CELL     = 16,
    parameter int CW         = 5,
    parameter int SETTLE_CYC = 8,
    parameter int INIT_CODE  = 8
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_start,
    input  logic              i_abort,
    input  logic              i_pd_early,
    output logic [N_CELL-1:0] o_sel,
    output logic [CW-1:0]     o_code,
    output logic              o_busy,
    output logic              o_lock,
    output logic              o_err,
    output logic              o_done
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_SAMPLE,
        ST_LOCK,
        ST_ERR
    } state_t;

    localparam int               CNT_W     = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(SETTLE_CYC - 1);
    localparam logic [CW-1:0]    CODE_MAX  = CW'(N_CELL);
    localparam logic [CW-1:0]    CODE_INIT = CW'(INIT_CODE);

    state_t            state, state_nxt;
    logic [CNT_W-1:0]  cnt, cnt_nxt;
    logic              dir, dir_nxt;
    logic              dir_vld, dir_vld_nxt;
    logic [CW-1:0]     code_nxt;
    logic [N_CELL-1:0] sel_nxt;
    logic              done_nxt;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            dir     <= 1'b0;
            dir_vld <= 1'b0;
            o_code  <= '0;
            o_sel   <= '0;
            o_busy  <= 1'b0;
            o_lock  <= 1'b0;
            o_err   <= 1'b0;
            o_done  <= 1'b0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            dir     <= dir_nxt;
            dir_vld <= dir_vld_nxt;
            o_code  <= code_nxt;
            o_sel   <= sel_nxt;
            o_busy  <= (state_nxt == ST_SETTLE) || (state_nxt == ST_SAMPLE);
            o_lock  <= (state_nxt == ST_LOCK);
            o_err   <= (state_nxt == ST_ERR);
            o_done  <= done_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        dir_nxt     = dir;
        dir_vld_nxt = dir_vld;
        code_nxt    = o_code;
        done_nxt    = 1'b0;

        case (state)
            ST_IDLE, ST_LOCK, ST_ERR: begin
                if (i_start) begin
                    code_nxt    = CODE_INIT;
                    dir_vld_nxt = 1'b0;
                    cnt_nxt     = '0;
                    state_nxt   = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (i_abort) begin
                    state_nxt = ST_IDLE;
                end else if (cnt == CNT_LAST) begin
                    state_nxt = ST_SAMPLE;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            ST_SAMPLE: begin
                // Abort wins over the lock/error/step decision.
                if (i_abort) begin
                    state_nxt = ST_IDLE;
                end else if (dir_vld && (i_pd_early != dir)) begin
                    state_nxt = ST_LOCK;
                    done_nxt  = 1'b1;
                end else if ((i_pd_early && (o_code == CODE_MAX)) ||
                             (!i_pd_early && (o_code == '0))) begin
                    state_nxt = ST_ERR;
                    done_nxt  = 1'b1;
                end else begin
                    dir_nxt     = i_pd_early;
                    dir_vld_nxt = 1'b1;
                    code_nxt    = i_pd_early ? (o_code + 1'b1) : (o_code - 1'b1);
                    cnt_nxt     = '0;
                    state_nxt   = ST_SETTLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase

        sel_nxt = '0;
        for (int j = 0; j < N_CELL; j++) begin
            sel_nxt[j] = (j < int'(code_nxt));
        end
    end

endmodule

// File: tb/tb_u_dly_cal_ctrl.sv
// Scoreboard bench for u_dly_cal_ctrl: a target-code phase detector drives the DUT and a
// closed-form model predicts the final code, outcome and completion cycle of each run.
module tb_u_dly_cal_ctrl;

    localparam int N_CELL     = 16;
    localparam int CW         = 5;
    localparam int SETTLE_CYC = 8;
    localparam int INIT_CODE  = 8;
    localparam int EVAL       = SETTLE_CYC + 1;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              start = 1'b0;
    logic              abort = 1'b0;
    logic              pd_early;
    logic [N_CELL-1:0] sel;
    logic [CW-1:0]     code;
    logic              busy, lock, err, done;

    bit clk_en = 1'b0;
    int target = 0;
    int cyc    = 0;
    int checks = 0;
    int errors = 0;

    typedef struct {
        bit lock;
        int code;
        int due;
    } exp_t;

    exp_t sb_q[$];

    u_dly_cal_ctrl #(
        .N_CELL    (N_CELL),
        .CW        (CW),
        .SETTLE_CYC(SETTLE_CYC),
        .INIT_CODE (INIT_CODE)
    ) dut (
        .i_clk     (clk),
        .i_rst     (rst),
        .i_start   (start),
        .i_abort   (abort),
        .i_pd_early(pd_early),
        .o_sel     (sel),
        .o_code    (code),
        .o_busy    (busy),
        .o_lock    (lock),
        .o_err     (err),
        .o_done    (done)
    );

    always #5 if (clk_en) clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Delay line with its ideal point between codes target-1 and target.
    assign pd_early = (int'(code) < target);

    task automatic check(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
                     name, act, act, exp, exp, cyc);
        end
    endtask

    function automatic int thermo(int c);
        return int'((33'h1 << c) - 33'h1);
    endfunction

    // Walking up stops on the first code >= target; walking down stops on target-1.
    function automatic exp_t model(int t, int s);
        exp_t e;
        int   k;
        if (INIT_CODE < t) begin
            if (t <= N_CELL) begin e.lock = 1; e.code = t;      k = t - INIT_CODE; end
            else             begin e.lock = 0; e.code = N_CELL; k = N_CELL - INIT_CODE; end
        end else begin
            if (t >= 1)      begin e.lock = 1; e.code = t - 1;  k = INIT_CODE - (t - 1); end
            else             begin e.lock = 0; e.code = 0;      k = INIT_CODE; end
        end
        e.due = s + (k + 1) * EVAL;
        return e;
    endfunction

    bit prev_done = 1'b0;
    always @(negedge clk) begin
        if (rst) begin
            prev_done = 1'b0;
        end else begin
            check("sel_thermo", int'(sel), thermo(int'(code)));
            if (prev_done) check("done_pulse_width", int'(done), 0);
            if (done) begin
                if (sb_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done: got done=1 expected no completion at cycle %0d", cyc);
                end else begin
                    exp_t e;
                    e = sb_q.pop_front();
                    check("done_cycle", cyc, e.due);
                    check("final_code", int'(code), e.code);
                    check("final_lock", int'(lock), int'(e.lock));
                    check("final_err", int'(err), int'(!e.lock));
                    check("busy_at_done", int'(busy), 0);
                end
            end
            prev_done = done;
        end
    end

    task automatic start_cal(int t, bit push);
        @(negedge clk);
        target = t;
        start  = 1'b1;
        if (push) sb_q.push_back(model(t, cyc + 1));
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (sb_q.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (sb_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL done_timeout: got no done after %0d cycles expected completion", n);
            sb_q.delete();
        end
    endtask

    task automatic check_reset_outputs(string tag);
        check({tag, "_sel"},  int'(sel),  0);
        check({tag, "_code"}, int'(code), 0);
        check({tag, "_busy"}, int'(busy), 0);
        check({tag, "_lock"}, int'(lock), 0);
        check({tag, "_err"},  int'(err),  0);
        check({tag, "_done"}, int'(done), 0);
    endtask

    initial begin
        #1 rst = 1'b1;
        #3 check_reset_outputs("rst_noclk");
        #10 clk_en = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;

        start_cal(11, 1'b1); wait_done();
        check("lock_up_sel", int'(sel), 16'h07FF);
        start_cal(17, 1'b1); wait_done();
        check("sat_high_sel", int'(sel), 16'hFFFF);
        start_cal(0, 1'b1);  wait_done();
        start_cal(5, 1'b1);  wait_done();

        // Abort during the second settle, with an ignored start just before it.
        start_cal(12, 1'b0);
        begin
            int n;
            n = 0;
            while (code != CW'(9) && n < 40) begin
                @(negedge clk);
                n++;
            end
            check("abort_reach_code9", int'(code), 9);
        end
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("ignored_start_code", int'(code), 9);
        check("ignored_start_busy", int'(busy), 1);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort_busy", int'(busy), 0);
        check("abort_code", int'(code), 9);
        check("abort_done", int'(done), 0);
        check("abort_lock", int'(lock), 0);
        check("abort_err",  int'(err),  0);
        repeat (3) @(negedge clk);
        check("abort_stays_idle", int'(busy), 0);
        start_cal(9, 1'b1);
        check("restart_code", int'(code), INIT_CODE);
        check("restart_busy", int'(busy), 1);
        wait_done();

        // Reset asserted while in SAMPLE of the first evaluation.
        start_cal(14, 1'b0);
        repeat (SETTLE_CYC) @(negedge clk);
        check("pre_rst_busy", int'(busy), 1);
        rst = 1'b1;
        #1 check_reset_outputs("rst_mid");
        @(negedge clk);
        rst = 1'b0;
        start_cal(14, 1'b1);
        check("post_rst_code", int'(code), INIT_CODE);
        wait_done();

        repeat (10) begin
            start_cal(int'($urandom_range(0, N_CELL + 1)), 1'b1);
            wait_done();
        end

        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish by %0t expected end of stimulus", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
